// File: rtl/rv32i_multicycle_ctrl.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXECUTE/MEM/WB/TRAP, drives datapath enables and memory handshakes.
// Latency: branch 3, ALU/LUI/AUIPC/jump/store 4, load 5 cycles, each plus memory wait cycles.
// Backpressure: IMem/DMem requests held until ack; ACK_TIMEOUT-1 cycles without ack -> sticky bus error, TRAP until reset.
// Optional: define RV_ILLEGAL_TRAP_EN to trap on illegal instructions; otherwise they retire nothing and act as a NOP.
module rv32i_multicycle_ctrl #(
  parameter int ALU_CTRL_W  = 4,
  parameter int ACK_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                  iClk,
  input  logic                  iRst_n,
  input  logic [31:0]           iInst,
  input  logic                  iIMem_Ack,
  input  logic                  iDMem_Ack,
  output logic                  oIMem_Req,
  output logic                  oIR_En,
  output logic                  oDMem_Req,
  output logic                  oDMem_We,
  output logic [ALU_CTRL_W-1:0] oALU_Ctrl,
  output logic                  oALU_SrcB,
  output logic                  oWrEn,
  output logic [1:0]            oWb_Sel,
  output logic                  oPC_En,
  output logic                  oJump,
  output logic                  oBranch,
  output logic                  oBus_Err,
  output logic                  oIllegal,
  output logic [CNT_W-1:0]      oInstret
);

  localparam int WAIT_W = $clog2(ACK_TIMEOUT);
  // Last wait cycle on which an ack is still accepted; no ack here means timeout.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 2);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = ALU_CTRL_W'(0);
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = ALU_CTRL_W'(1);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL  = ALU_CTRL_W'(2);
  localparam logic [ALU_CTRL_W-1:0] ALU_SRL  = ALU_CTRL_W'(3);
  localparam logic [ALU_CTRL_W-1:0] ALU_SRA  = ALU_CTRL_W'(4);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = ALU_CTRL_W'(5);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = ALU_CTRL_W'(6);
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = ALU_CTRL_W'(7);
  localparam logic [ALU_CTRL_W-1:0] ALU_OR   = ALU_CTRL_W'(8);
  localparam logic [ALU_CTRL_W-1:0] ALU_AND  = ALU_CTRL_W'(9);

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_TRAP
  } state_t;

  typedef enum logic [3:0] {
    C_NONE, C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_LUI, C_AUIPC, C_JAL, C_JALR
  } class_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic [CNT_W-1:0]    r_instret;
  logic                r_bus_err;

  class_t              w_class;
  logic                w_legal;
  logic [6:0]          w_opcode;
  logic [2:0]          w_funct3;
  logic [6:0]          w_funct7;
  logic                w_rd_nz;
  logic                w_unused;
  logic                w_timeout;
  logic                w_set_bus_err;
  logic                w_retire;
  logic [ALU_CTRL_W-1:0] w_alu_rri;
  logic [ALU_CTRL_W-1:0] w_alu_br;
`ifdef RV_ILLEGAL_TRAP_EN
  logic                w_set_illegal;
  logic                r_illegal;
`endif

  assign w_opcode  = iInst[6:0];
  assign w_funct3  = iInst[14:12];
  assign w_funct7  = iInst[31:25];
  assign w_rd_nz   = |iInst[11:7];
  // Register specifiers are consumed by the datapath, not by the sequencer.
  assign w_unused  = ^iInst[24:15];
  assign w_timeout = (r_wait_cnt == WAIT_LAST);

  // Opcode classification and legality of the funct fields
  always_comb begin
    w_class = C_NONE;
    w_legal = 1'b0;
    case (w_opcode)
      OP_R: begin
        w_class = C_R;
        w_legal = (w_funct7 == 7'h00) ||
                  ((w_funct7 == 7'h20) && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)));
      end
      OP_I: begin
        w_class = C_I;
        if (w_funct3 == 3'b001)      w_legal = (w_funct7 == 7'h00);
        else if (w_funct3 == 3'b101) w_legal = (w_funct7 == 7'h00) || (w_funct7 == 7'h20);
        else                         w_legal = 1'b1;
      end
      OP_LOAD: begin
        w_class = C_LOAD;
        w_legal = !((w_funct3 == 3'b011) || (w_funct3 == 3'b110) || (w_funct3 == 3'b111));
      end
      OP_STORE: begin
        w_class = C_STORE;
        w_legal = (w_funct3 <= 3'b010);
      end
      OP_BRANCH: begin
        w_class = C_BRANCH;
        w_legal = !((w_funct3 == 3'b010) || (w_funct3 == 3'b011));
      end
      OP_LUI:   begin w_class = C_LUI;   w_legal = 1'b1; end
      OP_AUIPC: begin w_class = C_AUIPC; w_legal = 1'b1; end
      OP_JAL:   begin w_class = C_JAL;   w_legal = 1'b1; end
      OP_JALR: begin
        w_class = C_JALR;
        w_legal = (w_funct3 == 3'b000);
      end
      default: begin
        w_class = C_NONE;
        w_legal = 1'b0;
      end
    endcase
  end

  // ALU op for R-type/I-ALU (SUB only exists in R-type) and for branch compares
  always_comb begin
    w_alu_rri = ALU_ADD;
    case (w_funct3)
      3'b000:  w_alu_rri = ((w_class == C_R) && w_funct7[5]) ? ALU_SUB : ALU_ADD;
      3'b001:  w_alu_rri = ALU_SLL;
      3'b010:  w_alu_rri = ALU_SLT;
      3'b011:  w_alu_rri = ALU_SLTU;
      3'b100:  w_alu_rri = ALU_XOR;
      3'b101:  w_alu_rri = w_funct7[5] ? ALU_SRA : ALU_SRL;
      3'b110:  w_alu_rri = ALU_OR;
      default: w_alu_rri = ALU_AND;
    endcase
    w_alu_br = ALU_SUB;
    if (w_funct3[2]) w_alu_br = w_funct3[1] ? ALU_SLTU : ALU_SLT;
  end

  // Next-state and per-state datapath/memory controls
  always_comb begin
    w_next_state  = r_state;
    w_set_bus_err = 1'b0;
`ifdef RV_ILLEGAL_TRAP_EN
    w_set_illegal = 1'b0;
`endif
    oIMem_Req = 1'b0;
    oIR_En    = 1'b0;
    oDMem_Req = 1'b0;
    oDMem_We  = 1'b0;
    oALU_Ctrl = ALU_ADD;
    oALU_SrcB = 1'b0;
    oWrEn     = 1'b0;
    oWb_Sel   = WB_ALU;
    oPC_En    = 1'b0;
    oJump     = 1'b0;
    oBranch   = 1'b0;
    case (r_state)
      S_FETCH: begin
        oIMem_Req = 1'b1;
        if (iIMem_Ack) begin
          oIR_En       = 1'b1;
          w_next_state = S_DECODE;
        end else if (w_timeout) begin
          w_set_bus_err = 1'b1;
          w_next_state  = S_TRAP;
        end
      end
      S_DECODE: begin
        if (w_legal) begin
          w_next_state = S_EXECUTE;
        end else begin
`ifdef RV_ILLEGAL_TRAP_EN
          w_set_illegal = 1'b1;
          w_next_state  = S_TRAP;
`else
          oPC_En       = 1'b1;
          w_next_state = S_FETCH;
`endif
        end
      end
      S_EXECUTE: begin
        w_next_state = S_WB;
        case (w_class)
          C_R: oALU_Ctrl = w_alu_rri;
          C_I: begin
            oALU_Ctrl = w_alu_rri;
            oALU_SrcB = 1'b1;
          end
          C_LOAD, C_STORE: begin
            oALU_SrcB    = 1'b1;
            w_next_state = S_MEM;
          end
          C_AUIPC, C_JAL, C_JALR: oALU_SrcB = 1'b1;
          C_LUI: oALU_Ctrl = ALU_ADD;
          C_BRANCH: begin
            oALU_Ctrl    = w_alu_br;
            oBranch      = 1'b1;
            oPC_En       = 1'b1;
            w_next_state = S_FETCH;
          end
          default: w_next_state = S_FETCH;
        endcase
      end
      S_MEM: begin
        oDMem_Req = 1'b1;
        oDMem_We  = (w_class == C_STORE);
        if (iDMem_Ack) begin
          if (w_class == C_STORE) begin
            oPC_En       = 1'b1;
            w_next_state = S_FETCH;
          end else begin
            w_next_state = S_WB;
          end
        end else if (w_timeout) begin
          w_set_bus_err = 1'b1;
          w_next_state  = S_TRAP;
        end
      end
      S_WB: begin
        oWrEn        = w_rd_nz;
        oPC_En       = 1'b1;
        w_next_state = S_FETCH;
        case (w_class)
          C_LOAD: oWb_Sel = WB_MEM;
          C_LUI:  oWb_Sel = WB_IMM;
          C_JAL, C_JALR: begin
            oWb_Sel = WB_PC4;
            oJump   = 1'b1;
          end
          default: oWb_Sel = WB_ALU;
        endcase
      end
      default: w_next_state = S_TRAP;
    endcase
  end

  // An instruction retires when control returns to FETCH after it has executed
  assign w_retire = (w_next_state == S_FETCH) &&
                    ((r_state == S_EXECUTE) || (r_state == S_MEM) || (r_state == S_WB));

  // State register
  always_ff @(posedge iClk) begin
    if (!iRst_n) r_state <= S_FETCH;
    else         r_state <= w_next_state;
  end

  // Ack wait counter: restarts on every state change, counts while a request is outstanding
  always_ff @(posedge iClk) begin
    if (!iRst_n)                                        r_wait_cnt <= '0;
    else if (w_next_state != r_state)                   r_wait_cnt <= '0;
    else if ((r_state == S_FETCH) || (r_state == S_MEM)) r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
  end

  // Retired-instruction counter (wraps) and sticky bus-error flag
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      r_instret <= '0;
      r_bus_err <= 1'b0;
    end else begin
      if (w_retire)      r_instret <= r_instret + CNT_W'(1);
      if (w_set_bus_err) r_bus_err <= 1'b1;
    end
  end

`ifdef RV_ILLEGAL_TRAP_EN
  // Sticky illegal-instruction flag
  always_ff @(posedge iClk) begin
    if (!iRst_n)            r_illegal <= 1'b0;
    else if (w_set_illegal) r_illegal <= 1'b1;
  end
  assign oIllegal = r_illegal;
`else
  assign oIllegal = 1'b0;
`endif

  assign oBus_Err = r_bus_err;
  assign oInstret = r_instret;

endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// Bench for rv32i_multicycle_ctrl: directed vector table, hand-written timeout/reset sequences, random instructions.
// Every cycle's outputs are compared with expectations derived from per-class instruction behaviour.
// Instret counter is instantiated 4 bits wide so wrap-around occurs within the run.
module tb_rv32i_multicycle_ctrl;

  localparam int P_BR = 0, P_ST = 1, P_LD = 2, P_WB = 3;

  logic        iClk, iRst_n, iIMem_Ack, iDMem_Ack;
  logic [31:0] iInst;
  logic        oIMem_Req, oIR_En, oDMem_Req, oDMem_We, oALU_SrcB, oWrEn;
  logic        oPC_En, oJump, oBranch, oBus_Err, oIllegal;
  logic [3:0]  oALU_Ctrl, oInstret;
  logic [1:0]  oWb_Sel;

  rv32i_multicycle_ctrl #(.ALU_CTRL_W(4), .ACK_TIMEOUT(16), .CNT_W(4)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iInst(iInst), .iIMem_Ack(iIMem_Ack), .iDMem_Ack(iDMem_Ack),
    .oIMem_Req(oIMem_Req), .oIR_En(oIR_En), .oDMem_Req(oDMem_Req), .oDMem_We(oDMem_We),
    .oALU_Ctrl(oALU_Ctrl), .oALU_SrcB(oALU_SrcB), .oWrEn(oWrEn), .oWb_Sel(oWb_Sel),
    .oPC_En(oPC_En), .oJump(oJump), .oBranch(oBranch), .oBus_Err(oBus_Err),
    .oIllegal(oIllegal), .oInstret(oInstret)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  typedef struct packed {
    logic       imem_req, ir_en, dmem_req, dmem_we;
    logic [3:0] alu;
    logic       srcb, wren;
    logic [1:0] wb_sel;
    logic       pc_en, jump, branch, bus_err, illegal;
    logic [3:0] instret;
  } outs_t;

  typedef struct {
    logic [31:0] inst;
    logic        legal;
    int          path;
    logic [3:0]  alu;
    logic        srcb;
    logic [1:0]  wbsel;
    logic        jump;
    int          iw;
    int          dw;
  } vec_t;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   m_instret = 0;
  logic m_bus_err = 1'b0;
  logic m_illegal = 1'b0;

  localparam int R_OPS [8] = '{0, 2, 5, 6, 7, 3, 8, 9};

  function automatic outs_t idle();
    outs_t e;
    e = '0;
    e.instret = 4'(m_instret % 16);
    e.bus_err = m_bus_err;
    e.illegal = m_illegal;
    return e;
  endfunction

  function automatic vec_t mk(input logic [31:0] inst, input logic legal, input int path,
                              input int alu, input logic srcb, input int wbsel, input logic jump,
                              input int iw, input int dw);
    vec_t v;
    v.inst = inst; v.legal = legal; v.path = path; v.alu = 4'(alu); v.srcb = srcb;
    v.wbsel = 2'(wbsel); v.jump = jump; v.iw = iw; v.dw = dw;
    return v;
  endfunction

  // Reference: per-class expectations straight from the ISA rules
  function automatic vec_t model(input logic [31:0] inst);
    vec_t v;
    logic [6:0] op; logic [2:0] f3; logic [6:0] f7;
    op = inst[6:0]; f3 = inst[14:12]; f7 = inst[31:25];
    v = mk(inst, 1'b1, P_WB, 0, 1'b0, 0, 1'b0, 0, 0);
    case (op)
      7'h33: begin
        v.legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        v.alu = 4'(R_OPS[f3]);
        if (f7 == 7'h20) v.alu = (f3 == 3'd0) ? 4'd1 : 4'd4;
      end
      7'h13: begin
        v.srcb = 1'b1;
        v.alu = 4'(R_OPS[f3]);
        if (f3 == 3'd5 && f7 == 7'h20) v.alu = 4'd4;
        if (f3 == 3'd1) v.legal = (f7 == 7'h00);
        if (f3 == 3'd5) v.legal = (f7 == 7'h00) || (f7 == 7'h20);
      end
      7'h03: begin v.path = P_LD; v.srcb = 1'b1; v.wbsel = 2'd1; v.legal = !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7); end
      7'h23: begin v.path = P_ST; v.srcb = 1'b1; v.legal = (f3 <= 3'd2); end
      7'h63: begin
        v.path = P_BR;
        v.alu = (f3 >= 3'd6) ? 4'd6 : (f3 >= 3'd4) ? 4'd5 : 4'd1;
        v.legal = !(f3 == 3'd2 || f3 == 3'd3);
      end
      7'h37: v.wbsel = 2'd3;
      7'h17: v.srcb = 1'b1;
      7'h6F: begin v.srcb = 1'b1; v.wbsel = 2'd2; v.jump = 1'b1; end
      7'h67: begin v.srcb = 1'b1; v.wbsel = 2'd2; v.jump = 1'b1; v.legal = (f3 == 3'd0); end
      default: v.legal = 1'b0;
    endcase
    return v;
  endfunction

  task automatic check(input string name, input outs_t e);
    outs_t a;
    a = {oIMem_Req, oIR_En, oDMem_Req, oDMem_We, oALU_Ctrl, oALU_SrcB, oWrEn, oWb_Sel,
         oPC_En, oJump, oBranch, oBus_Err, oIllegal, oInstret};
    n_checks++;
    if (a === e) n_pass++;
    else $display("FAIL %s (inst %h): got %b required %b [imreq,iren,dreq,dwe,alu4,srcb,wren,wb2,pcen,jmp,br,berr,ill,ret4]",
                  name, iInst, a, e);
  endtask

  task automatic cyc(input logic ia, input logic da, input logic [31:0] inst, input outs_t e, input string name);
    @(negedge iClk);
    iRst_n = 1'b1; iIMem_Ack = ia; iDMem_Ack = da; iInst = inst;
    #1;
    check(name, e);
  endtask

  task automatic do_reset();
    outs_t e;
    @(negedge iClk);
    iRst_n = 1'b0; iIMem_Ack = 1'b0; iDMem_Ack = 1'b0;
    @(negedge iClk);
    m_instret = 0; m_bus_err = 1'b0; m_illegal = 1'b0;
    #1;
    e = idle(); e.imem_req = 1'b1;
    check("reset_state", e);
  endtask

  task automatic run_vec(input vec_t v);
    outs_t e;
    logic  st;
    st = (v.path == P_ST);
    for (int k = 0; k < v.iw; k++) begin
      e = idle(); e.imem_req = 1'b1;
      cyc(1'b0, 1'b0, v.inst, e, "fetch_wait");
    end
    e = idle(); e.imem_req = 1'b1; e.ir_en = 1'b1;
    cyc(1'b1, 1'b0, v.inst, e, "fetch_ack");
    e = idle();
    if (!v.legal) begin
`ifdef RV_ILLEGAL_TRAP_EN
      cyc(1'b0, 1'b0, v.inst, e, "decode_illegal");
      m_illegal = 1'b1;
      e = idle();
      cyc(1'b1, 1'b1, v.inst, e, "trap_illegal");
      cyc(1'b1, 1'b1, v.inst, e, "trap_illegal_hold");
      do_reset();
`else
      e.pc_en = 1'b1;
      cyc(1'b0, 1'b0, v.inst, e, "decode_nop");
`endif
      return;
    end
    cyc(1'b0, 1'b0, v.inst, e, "decode");
    e = idle(); e.alu = v.alu; e.srcb = v.srcb;
    if (v.path == P_BR) begin
      e.branch = 1'b1; e.pc_en = 1'b1;
      cyc(1'b0, 1'b0, v.inst, e, "execute_branch");
      m_instret++;
      return;
    end
    cyc(1'b0, 1'b0, v.inst, e, "execute");
    if (v.path == P_ST || v.path == P_LD) begin
      for (int k = 0; k < v.dw; k++) begin
        e = idle(); e.dmem_req = 1'b1; e.dmem_we = st;
        cyc(1'b0, 1'b0, v.inst, e, "mem_wait");
      end
      e = idle(); e.dmem_req = 1'b1; e.dmem_we = st; e.pc_en = st;
      cyc(1'b0, 1'b1, v.inst, e, "mem_ack");
      if (st) begin
        m_instret++;
        return;
      end
    end
    e = idle(); e.wren = (v.inst[11:7] != 5'd0); e.pc_en = 1'b1; e.wb_sel = v.wbsel; e.jump = v.jump;
    cyc(1'b0, 1'b0, v.inst, e, "writeback");
    m_instret++;
  endtask

  vec_t tbl [20];

  initial begin
    outs_t e;
    vec_t  v;
    logic [6:0] ops [9];
    int sel;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67};
    iRst_n = 1'b0; iIMem_Ack = 1'b0; iDMem_Ack = 1'b0; iInst = 32'h0;

    //              inst          legal path  alu srcb wb jump iw  dw
    tbl[0]  = mk(32'h002081B3, 1'b1, P_WB, 0, 1'b0, 0, 1'b0, 0,  0);  // ADD x3,x1,x2
    tbl[1]  = mk(32'h0020A023, 1'b1, P_ST, 0, 1'b1, 0, 1'b0, 0,  3);  // SW, ack after 3 waits
    tbl[2]  = mk(32'h0020E063, 1'b1, P_BR, 6, 1'b0, 0, 1'b0, 1,  0);  // BLTU
    tbl[3]  = mk(32'h0000A283, 1'b1, P_LD, 0, 1'b1, 1, 1'b0, 2,  1);  // LW x5
    tbl[4]  = mk(32'h402081B3, 1'b1, P_WB, 1, 1'b0, 0, 1'b0, 0,  0);  // SUB
    tbl[5]  = mk(32'h4020D1B3, 1'b1, P_WB, 4, 1'b0, 0, 1'b0, 0,  0);  // SRA
    tbl[6]  = mk(32'h4030D193, 1'b1, P_WB, 4, 1'b1, 0, 1'b0, 0,  0);  // SRAI
    tbl[7]  = mk(32'h0050B193, 1'b1, P_WB, 6, 1'b1, 0, 1'b0, 0,  0);  // SLTIU
    tbl[8]  = mk(32'h123451B7, 1'b1, P_WB, 0, 1'b0, 3, 1'b0, 14, 0);  // LUI, fetch ack on last cycle
    tbl[9]  = mk(32'h00001197, 1'b1, P_WB, 0, 1'b1, 0, 1'b0, 0,  0);  // AUIPC
    tbl[10] = mk(32'h008000EF, 1'b1, P_WB, 0, 1'b1, 2, 1'b1, 0,  0);  // JAL x1
    tbl[11] = mk(32'h00008067, 1'b1, P_WB, 0, 1'b1, 2, 1'b1, 0,  0);  // JALR x0 (no write)
    tbl[12] = mk(32'h0000007F, 1'b0, P_WB, 0, 1'b0, 0, 1'b0, 0,  0);  // unknown opcode
    tbl[13] = mk(32'h402091B3, 1'b0, P_WB, 0, 1'b0, 0, 1'b0, 0,  0);  // funct7=0x20 with SLL
    tbl[14] = mk(32'h0020D063, 1'b1, P_BR, 5, 1'b0, 0, 1'b0, 0,  0);  // BGE
    tbl[15] = mk(32'h0020C033, 1'b1, P_WB, 7, 1'b0, 0, 1'b0, 0,  0);  // XOR x0 (no write)
    tbl[16] = mk(32'h40209193, 1'b0, P_WB, 0, 1'b0, 0, 1'b0, 0,  0);  // SLLI bad funct7
    tbl[17] = mk(32'h00208063, 1'b1, P_BR, 1, 1'b0, 0, 1'b0, 0,  0);  // BEQ
    tbl[18] = mk(32'h0000B283, 1'b0, P_LD, 0, 1'b1, 1, 1'b0, 0,  0);  // LD funct3=011 illegal
    tbl[19] = mk(32'h0000C283, 1'b1, P_LD, 0, 1'b1, 1, 1'b0, 0,  14); // LBU, data ack on last cycle

    do_reset();
    for (int i = 0; i < 20; i++) run_vec(tbl[i]);

    // Fetch timeout: 15 unanswered cycles, then TRAP with sticky bus error, acks ignored
    do_reset();
    for (int k = 0; k < 15; k++) begin
      e = idle(); e.imem_req = 1'b1;
      cyc(1'b0, 1'b0, 32'h00000013, e, "fetch_timeout_wait");
    end
    m_bus_err = 1'b1;
    for (int k = 0; k < 3; k++) begin
      e = idle();
      cyc(1'b1, 1'b1, 32'h00000013, e, "fetch_timeout_trap");
    end

    // Data timeout during a load
    do_reset();
    e = idle(); e.imem_req = 1'b1; e.ir_en = 1'b1;
    cyc(1'b1, 1'b0, 32'h0000A283, e, "ld_to_fetch");
    e = idle();
    cyc(1'b0, 1'b0, 32'h0000A283, e, "ld_to_decode");
    e = idle(); e.srcb = 1'b1;
    cyc(1'b0, 1'b0, 32'h0000A283, e, "ld_to_execute");
    for (int k = 0; k < 15; k++) begin
      e = idle(); e.dmem_req = 1'b1;
      cyc(1'b0, 1'b0, 32'h0000A283, e, "mem_timeout_wait");
    end
    m_bus_err = 1'b1;
    e = idle();
    cyc(1'b0, 1'b1, 32'h0000A283, e, "mem_timeout_trap");

    // Reset in the middle of a load's MEM wait
    do_reset();
    run_vec(tbl[0]);
    run_vec(tbl[9]);
    e = idle(); e.imem_req = 1'b1; e.ir_en = 1'b1;
    cyc(1'b1, 1'b0, 32'h0000A283, e, "mid_mem_fetch");
    e = idle();
    cyc(1'b0, 1'b0, 32'h0000A283, e, "mid_mem_decode");
    e = idle(); e.srcb = 1'b1;
    cyc(1'b0, 1'b0, 32'h0000A283, e, "mid_mem_execute");
    e = idle(); e.dmem_req = 1'b1;
    cyc(1'b0, 1'b0, 32'h0000A283, e, "mid_mem_wait");
    do_reset();

    // Random instructions against the reference
    for (int i = 0; i < 60; i++) begin
      logic [31:0] inst;
      inst = $urandom;
      sel = $urandom_range(0, 9);
      if (sel < 9) inst[6:0] = ops[sel];
      case ($urandom_range(0, 3))
        0, 1:    inst[31:25] = 7'h00;
        2:       inst[31:25] = 7'h20;
        default: ;
      endcase
      v = model(inst);
      v.iw = ($urandom_range(0, 7) == 0) ? 14 : $urandom_range(0, 3);
      v.dw = ($urandom_range(0, 7) == 0) ? 14 : $urandom_range(0, 3);
      run_vec(v);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
